// File: rtl/uart_tx_pkg.sv
// Shared definitions for the UART TX line path (scheduler and feeder).
//   t_txsched_state  : scheduler FSM encoding
//   c_uart_line_bytes: fixed feeder line length
//   c_line_of_spaces : idle line (spaces terminated by CR LF)
//   f_blank_line     : same idle line for any length up to c_max_line_bytes
package uart_tx_pkg;

  typedef enum logic [1:0] {
    S_IDLE    = 2'd0,
    S_GRANT   = 2'd1,
    S_SEND    = 2'd2,
    S_RELEASE = 2'd3
  } t_txsched_state;

  localparam int c_uart_line_bytes = 34;
  localparam int c_max_line_bytes  = 63;

  localparam logic [c_uart_line_bytes*8-1:0] c_line_of_spaces =
    {{(c_uart_line_bytes-2){8'h20}}, 8'h0D, 8'h0A};

  // Byte 0 is the LSB byte, i.e. the last character sent.
  function automatic logic [c_max_line_bytes*8-1:0] f_blank_line(input int n_bytes);
    logic [c_max_line_bytes*8-1:0] line;
    line = '0;
    for (int b = 0; b < c_max_line_bytes; b++) begin
      if (b < n_bytes) begin
        line[b*8 +: 8] = (b == 0) ? 8'h0A : ((b == 1) ? 8'h0D : 8'h20);
      end
    end
    return line;
  endfunction

endpackage

// File: rtl/uart_tx_line_sched_rr_arbiter.sv
// rr_arbiter_onehot: combinational round-robin pick.
//   i_req   : request vector
//   i_ptr   : index of the last winner; search starts at i_ptr+1 (mod N)
//   o_grant : one-hot winner, all zero when no request
module rr_arbiter_onehot #(
  parameter int N = 4
) (
  input  logic [N-1:0]         i_req,
  input  logic [$clog2(N)-1:0] i_ptr,
  output logic [N-1:0]         o_grant
);

  always_comb begin
    int idx;
    idx     = 0;
    o_grant = '0;
    for (int k = 1; k <= N; k++) begin
      idx = (int'(i_ptr) + k) % N;
      if (i_req[idx] && (o_grant == '0)) begin
        o_grant[idx] = 1'b1;
      end
    end
  end

endmodule

// File: rtl/uart_tx_line_sched.sv
// uart_tx_line_sched: shares the single fixed-length UART TX feeder between
// several line producers. Latches the winning line at grant, holds go while
// the feeder enqueues bytes, acks on the last byte, then releases the feeder
// for two cycles before the next grant.
//   i_clk_20mhz / i_rstn_20mhz : clock, synchronous active-low reset
//   i_req / i_req_lines        : level requests and their lines (MSB byte first)
//   o_grant / o_ack            : one-hot served requester, completion pulse
//   o_feed_go / o_feed_line    : feeder control and latched line
//   i_feed_valid               : one strobe per byte enqueued by the feeder
//   o_busy                     : high whenever not IDLE
// Build option: UART_TX_SCHED_FIXED_PRIO_EN selects fixed priority
// (lowest index wins) and drops the round-robin pointer.
//
// state   | meaning
// IDLE    | waiting for a request; latch winner and line on exit
// GRANT   | go high, byte counter cleared
// SEND    | go high, count feeder strobes until the last byte
// RELEASE | go low for two cycles so the feeder returns to idle
module uart_tx_line_sched
  import uart_tx_pkg::*;
#(
  parameter int N_REQ      = 4,
  parameter int LINE_BYTES = c_uart_line_bytes
) (
  input  logic                          i_clk_20mhz,
  input  logic                          i_rstn_20mhz,
  input  logic [N_REQ-1:0]              i_req,
  input  logic [N_REQ*LINE_BYTES*8-1:0] i_req_lines,
  output logic [N_REQ-1:0]              o_grant,
  output logic [N_REQ-1:0]              o_ack,
  output logic                          o_feed_go,
  output logic [LINE_BYTES*8-1:0]       o_feed_line,
  input  logic                          i_feed_valid,
  output logic                          o_busy
);

  localparam int LW = LINE_BYTES * 8;
  localparam int PW = $clog2(N_REQ);
  localparam logic [LW-1:0] c_reset_line = LW'(f_blank_line(LINE_BYTES));

  t_txsched_state r_state, w_state_nxt;
  logic [N_REQ-1:0] r_grant;
  logic [LW-1:0]    r_line;
  logic [5:0]       r_cnt;
  logic             r_rel_tmr;
  logic [N_REQ-1:0] w_arb_grant;
  logic [LW-1:0]    w_sel_line;
  logic [PW-1:0]    w_ptr;
  logic             w_last_byte;

`ifdef UART_TX_SCHED_FIXED_PRIO_EN
  // Pointer pinned to the top index so the search always starts at 0.
  assign w_ptr = PW'(N_REQ-1);
`else
  logic [PW-1:0] r_ptr;
  logic [PW-1:0] w_win_idx;

  always_comb begin
    w_win_idx = '0;
    for (int r = 0; r < N_REQ; r++) begin
      if (r_grant[r]) w_win_idx = PW'(r);
    end
  end

  always_ff @(posedge i_clk_20mhz) begin
    if (!i_rstn_20mhz) begin
      r_ptr <= PW'(N_REQ-1);
    end else if (r_state == S_RELEASE && r_rel_tmr) begin
      r_ptr <= w_win_idx;
    end
  end

  assign w_ptr = r_ptr;
`endif

  rr_arbiter_onehot #(.N(N_REQ)) u_arb (
    .i_req   (i_req),
    .i_ptr   (w_ptr),
    .o_grant (w_arb_grant)
  );

  always_comb begin
    w_sel_line = '0;
    for (int r = 0; r < N_REQ; r++) begin
      if (w_arb_grant[r]) w_sel_line = i_req_lines[r*LW +: LW];
    end
  end

  assign w_last_byte = (r_state == S_SEND) && i_feed_valid &&
                       (r_cnt == 6'(LINE_BYTES-1));

  always_ff @(posedge i_clk_20mhz) begin
    if (!i_rstn_20mhz) r_state <= S_IDLE;
    else               r_state <= w_state_nxt;
  end

  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      S_IDLE:    if (|i_req) w_state_nxt = S_GRANT;
      S_GRANT:   w_state_nxt = S_SEND;
      S_SEND:    if (w_last_byte) w_state_nxt = S_RELEASE;
      S_RELEASE: if (r_rel_tmr) w_state_nxt = S_IDLE;
      default:   w_state_nxt = S_IDLE;
    endcase
  end

  always_comb begin
    o_feed_go = (r_state == S_GRANT) || (r_state == S_SEND);
    o_busy    = (r_state != S_IDLE);
    o_ack     = w_last_byte ? r_grant : '0;
  end

  always_ff @(posedge i_clk_20mhz) begin
    if (!i_rstn_20mhz) begin
      r_grant   <= '0;
      r_line    <= c_reset_line;
      r_cnt     <= '0;
      r_rel_tmr <= 1'b0;
    end else begin
      case (r_state)
        S_IDLE: begin
          if (|i_req) begin
            r_grant <= w_arb_grant;
            r_line  <= w_sel_line;
          end
        end
        S_GRANT: r_cnt <= '0;
        S_SEND: begin
          r_rel_tmr <= 1'b0;
          if (i_feed_valid) r_cnt <= r_cnt + 6'd1;
        end
        S_RELEASE: begin
          r_rel_tmr <= 1'b1;
          if (r_rel_tmr) r_grant <= '0;
        end
        default: r_rel_tmr <= 1'b0;
      endcase
    end
  end

  assign o_grant     = r_grant;
  assign o_feed_line = r_line;

endmodule

// File: tb/tb_uart_tx_line_sched.sv
// Scoreboard bench for uart_tx_line_sched with a behavioural feeder model.
module tb_uart_tx_line_sched;

  localparam int NR = 4;
  localparam int LB = 34;
  localparam int LW = LB * 8;

  typedef struct {
    logic [NR-1:0] vec;
    logic [LW-1:0] line;
  } t_exp;

  logic              clk = 1'b0;
  logic              rstn;
  logic [NR-1:0]     req;
  logic [NR*LW-1:0]  lines;
  logic [NR-1:0]     grant, ack;
  logic              go;
  logic [LW-1:0]     feed_line;
  logic              feed_valid;
  logic              busy;

  logic              feed_ready;
  int                fb_st, fb_cnt;
  int                checks_n = 0;
  int                errors_n = 0;
  t_exp              grant_q[$];
  t_exp              ack_q[$];
  logic [NR-1:0]     prev_grant, prev_ack;
  logic              prev_go, seen_line;
  int                go_low_run;

  localparam logic [LW-1:0] RST_LINE = {{32{8'h20}}, 8'h0D, 8'h0A};

  uart_tx_line_sched #(.N_REQ(NR), .LINE_BYTES(LB)) dut (
    .i_clk_20mhz  (clk),
    .i_rstn_20mhz (rstn),
    .i_req        (req),
    .i_req_lines  (lines),
    .o_grant      (grant),
    .o_ack        (ack),
    .o_feed_go    (go),
    .o_feed_line  (feed_line),
    .i_feed_valid (feed_valid),
    .o_busy       (busy)
  );

  always #25 clk = ~clk;

  task automatic chk(input string tag, input logic [LW-1:0] got, input logic [LW-1:0] exp);
    checks_n++;
    if (got !== exp) begin
      errors_n++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  function automatic logic [LW-1:0] mk_line(input logic [7:0] c);
    logic [LW-1:0] l;
    for (int i = 0; i < LB; i++) begin
      if (i == LB-2)      l[(LB-1-i)*8 +: 8] = 8'h0D;
      else if (i == LB-1) l[(LB-1-i)*8 +: 8] = 8'h0A;
      else                l[(LB-1-i)*8 +: 8] = c + 8'(i);
    end
    return l;
  endfunction

  task automatic tick;
    @(negedge clk);
    #2;
  endtask

  task automatic push_grant(input logic [NR-1:0] v, input logic [LW-1:0] l);
    t_exp e;
    e.vec = v; e.line = l;
    grant_q.push_back(e);
  endtask

  task automatic push_ack(input logic [NR-1:0] v, input logic [LW-1:0] l);
    t_exp e;
    e.vec = v; e.line = l;
    ack_q.push_back(e);
  endtask

  task automatic wait_ack(input string tag);
    int n;
    n = 0;
    do begin
      tick;
      n++;
    end while (ack == '0 && n < 2000);
    if (ack == '0) chk({tag, "_ack_timeout"}, 0, 1);
  endtask

  task automatic wait_cnt(input string tag, input int target);
    int n;
    n = 0;
    while (fb_cnt != target && n < 2000) begin
      tick;
      n++;
    end
    if (fb_cnt != target) chk({tag, "_strobe_timeout"}, LW'(fb_cnt), LW'(target));
  endtask

  task automatic check_reset(input string tag);
    chk({tag, "_grant"}, LW'(grant), 0);
    chk({tag, "_ack"},   LW'(ack),   0);
    chk({tag, "_go"},    LW'(go),    0);
    chk({tag, "_line"},  feed_line,  RST_LINE);
    chk({tag, "_busy"},  LW'(busy),  0);
  endtask

  task automatic do_reset(input string tag);
    rstn = 1'b0;
    tick;
    tick;
    check_reset(tag);
    rstn = 1'b1;
    tick;
  endtask

  // Feeder model and output monitors share one process so the strobe is
  // settled before ack (combinational from the strobe) is sampled.
  initial begin
    fb_st = 0; fb_cnt = 0; feed_valid = 1'b0;
    prev_grant = '0; prev_ack = '0; prev_go = 1'b0;
    seen_line = 1'b0; go_low_run = 0;
    forever begin
      @(negedge clk);
      feed_valid = 1'b0;
      if (!rstn) begin
        fb_st = 0; fb_cnt = 0;
      end else begin
        case (fb_st)
          0: if (go) fb_st = 1;
          1: fb_st = 2;
          2: if (feed_ready) begin
               feed_valid = 1'b1;
               fb_cnt++;
               if (fb_cnt == LB) fb_st = 3;
             end
          default: if (!go) begin fb_st = 0; fb_cnt = 0; end
        endcase
      end
      #1;
      if (fb_st == 2 && rstn) chk("go_in_send", LW'(go), 1);
      if (grant != '0 && prev_grant == '0) begin
        if (grant_q.size() == 0) begin
          chk("grant_unexpected", LW'(grant), 0);
        end else begin
          t_exp e;
          e = grant_q.pop_front();
          chk("grant", LW'(grant), LW'(e.vec));
          chk("grant_line", feed_line, e.line);
          chk("go_at_grant", LW'(go), 1);
        end
      end
      if (go && !prev_go) begin
        if (seen_line) chk("go_gap_ge2", LW'(go_low_run >= 2), 1);
        seen_line = 1'b1;
      end
      if (ack != '0) begin
        chk("ack_one_cycle", LW'(prev_ack), 0);
        if (ack_q.size() == 0) begin
          chk("ack_unexpected", LW'(ack), 0);
        end else begin
          t_exp e;
          e = ack_q.pop_front();
          chk("ack", LW'(ack), LW'(e.vec));
          chk("ack_line", feed_line, e.line);
          chk("ack_strobe_count", LW'(fb_cnt), LW'(LB));
        end
      end
      if (go) go_low_run = 0;
      else    go_low_run++;
      prev_go = go; prev_grant = grant; prev_ack = ack;
    end
  end

  initial begin
    #(50 * 60000);
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [LW-1:0] l_orig;
    int low_cycles, acks_in_stall;
    rstn = 1'b0; req = '0; lines = '0; feed_ready = 1'b1;
    for (int r = 0; r < NR; r++) lines[r*LW +: LW] = mk_line(8'h41 + 8'(r));
    repeat (3) tick;
    check_reset("rst0");
    rstn = 1'b1;
    tick;

    // single request from requester 0
    push_grant(4'b0001, mk_line(8'h41));
    push_ack(4'b0001, mk_line(8'h41));
    req = 4'b0001;
    tick;
    chk("t1_go_next_cycle", LW'(go), 1);
    chk("t1_busy", LW'(busy), 1);
    wait_ack("t1");
    req = '0;
    tick;
    chk("t1_go_low_u1", LW'(go), 0);
    tick;
    chk("t1_busy_u2", LW'(busy), 1);
    tick;
    chk("t1_busy_u3", LW'(busy), 0);

    // several requesters held continuously
    do_reset("rst2");
`ifdef UART_TX_SCHED_FIXED_PRIO_EN
    for (int i = 0; i < 3; i++) begin
      push_grant(4'b0001, mk_line(8'h41));
      push_ack(4'b0001, mk_line(8'h41));
    end
    req = 4'b1001;
    for (int i = 0; i < 3; i++) wait_ack("t2");
`else
    for (int i = 0; i < 5; i++) begin
      push_grant(4'(1 << (i % NR)), mk_line(8'h41 + 8'(i % NR)));
      push_ack(4'(1 << (i % NR)), mk_line(8'h41 + 8'(i % NR)));
    end
    req = 4'b1111;
    for (int i = 0; i < 5; i++) wait_ack("t2");
`endif
    req = '0;
    repeat (4) tick;

    // requester 2 changes its line and drops request after grant
    l_orig = mk_line(8'h43);
    push_grant(4'b0100, l_orig);
    push_ack(4'b0100, l_orig);
    req = 4'b0100;
    tick;
    tick;
    lines[2*LW +: LW] = mk_line(8'h7A);
    req = '0;
    wait_ack("t3");
    repeat (4) tick;
    chk("t3_idle", LW'(busy), 0);

    // feeder stall inside SEND
    push_grant(4'b1000, mk_line(8'h44));
    push_ack(4'b1000, mk_line(8'h44));
    req = 4'b1000;
    wait_cnt("t4", 5);
    feed_ready = 1'b0;
    low_cycles = 0; acks_in_stall = 0;
    repeat (100) begin
      tick;
      if (!go) low_cycles++;
      if (ack != '0) acks_in_stall++;
    end
    chk("t4_go_low_in_stall", LW'(low_cycles), 0);
    chk("t4_ack_in_stall", LW'(acks_in_stall), 0);
    chk("t4_busy_in_stall", LW'(busy), 1);
    feed_ready = 1'b1;
    wait_ack("t4");
    req = '0;
    repeat (4) tick;

    // reset at the 10th strobe, then a fresh line for requester 1
    push_grant(4'b0001, mk_line(8'h41));
    req = 4'b0001;
    wait_cnt("t5", 10);
    rstn = 1'b0;
    req = '0;
    tick;
    check_reset("t5_rst");
    rstn = 1'b1;
    tick;
    push_grant(4'b0010, mk_line(8'h42));
    push_ack(4'b0010, mk_line(8'h42));
    req = 4'b0010;
    wait_ack("t5");
    req = '0;
    repeat (4) tick;
    chk("t5_idle", LW'(busy), 0);

    chk("grant_q_empty", LW'(grant_q.size()), 0);
    chk("ack_q_empty", LW'(ack_q.size()), 0);
    $display("Simulation finished: %0d checks, %0d errors", checks_n, errors_n);
    $finish;
  end

endmodule

// File: doc/uart_tx_line_sched.md
# uart_tx_line_sched

Round-robin scheduler that shares the single 34-byte-line UART TX feeder among several line producers, for example the accelerometer readout and the status/banner text generators. It arbitrates line requests, latches the winner's ASCII line, drives the feeder's go/line inputs, and counts the feeder's byte-valid strobes to detect completion. It acknowledges the requester and releases the feeder cleanly before the next grant. It sits between the text generators and the feeder, in the 20 MHz domain.

## Interface
- `N_REQ`, default 4: number of requesters, 2..8.
- `LINE_BYTES`, default 34: bytes per line. Must equal the feeder's fixed line length; range 1..63.
- `i_clk_20mhz`  in  1  system clock.
- `i_rstn_20mhz`  in  1  reset; synchronous, active-low.
- `i_req`  in  N_REQ  level request per requester. Held high until the matching `o_ack`.
- `i_req_lines`  in  N_REQ*LINE_BYTES*8  lines; requester r occupies slice [r*LINE_BYTES*8 +: LINE_BYTES*8]. The first character is in the MSB byte.
- `o_grant`  out  N_REQ  one-hot; marks the requester currently being served.
- `o_ack`  out  N_REQ  one-cycle pulse to the served requester when its last byte has been enqueued.
- `o_feed_go`  out  1  go level to the feeder.
- `o_feed_line`  out  LINE_BYTES*8  latched line to the feeder.
- `i_feed_valid`  in  1  the feeder's tx-valid strobe; one pulse per enqueued byte.
- `o_busy`  out  1  high in every state except IDLE.

## Operation
- FSM states:
  - IDLE: if any `i_req` bit is set, pick a winner, latch its line into `o_feed_line`, latch one-hot `o_grant`, go to GRANT. Otherwise stay in IDLE.
  - GRANT: `o_feed_go`=1. Clear the byte counter. Go to SEND unconditionally.
  - SEND: `o_feed_go`=1. Increment the 6-bit counter on each `i_feed_valid`. When `i_feed_valid` is high and counter==LINE_BYTES-1, pulse `o_ack`[winner] in the same cycle (combinational from state plus strobe) and go to RELEASE.
  - RELEASE: `o_feed_go`=0. Hold for exactly 2 cycles, counted by a 1-bit timer, so the feeder passes WAIT→IDLE. Then clear `o_grant`, update the round-robin pointer to the winner, and return to IDLE.
- Arbitration is round-robin. The search starts at pointer+1 modulo N_REQ; the pointer resets to N_REQ-1, so requester 0 wins first.
- The line is latched at the grant. A requester may change its line, or drop its request, after the grant. The service still completes and `o_ack` still pulses.
- `i_feed_valid` outside SEND is ignored.
- A feeder stall (tx-ready low) only lengthens SEND. There is no timeout.

## Timing
- Reset values: `o_grant`=0, `o_ack`=0, `o_feed_go`=0, `o_feed_line`=all 0x20 except the final two bytes, 0x0D 0x0A. `o_busy`=0, pointer=N_REQ-1, counter=0, state IDLE.
- Request sampled in IDLE at cycle t gives GRANT with `o_feed_go`=1 at t+1. The feeder enters capture at t+2.
- After the last strobe at cycle u: `o_ack` is high at u, go is low from u+1, and the block is back in IDLE at u+3. The next grant is no earlier than u+4.
- Reset taken mid-line returns to reset values on the next edge. The feeder must be reset in the same cycle; the top level inverts `i_rstn_20mhz` for the feeder.
- Simultaneous requests resolve by the pointer. A request arriving during service waits for IDLE.

## Configuration
- `UART_TX_SCHED_FIXED_PRIO_EN`:
  - Defined: fixed priority, lowest index wins, and the pointer logic is removed.
  - Undefined (default): round-robin as described above.

## Structure
- Shared package `uart_tx_pkg`:
  - state enum `t_txsched_state`
  - `c_uart_line_bytes` = 34
  - `c_line_of_spaces` constant, shared with the feeder
- One natural sub-module, `rr_arbiter_onehot`: a purely combinational request-vector plus pointer to one-hot grant function, reusable elsewhere.
- Counter, latch and FSM stay in this block.

## Test plan
- Single request: `i_req`=0001 with line "A…\r\n" → `o_feed_go` high 1 cycle later, 34 strobes forwarded, one `o_ack`[0] pulse on the 34th strobe, `o_busy` low 3 cycles later.
- All four requests held continuously → grant order 0,1,2,3,0. Each `o_ack` pulses exactly once per line. Go drops for ≥2 cycles between lines.
- Requester 2 changes its line and drops `i_req` one cycle after its grant → `o_feed_line` keeps the original bytes, and `o_ack`[2] still pulses after 34 strobes.
- Feeder ready held low 100 cycles inside SEND → go stays high and the counter holds. Completion occurs after the strobes resume.
- Reset asserted at the 10th strobe → next edge gives all outputs at reset values. After release, `i_req`=0010 is granted to requester 1 with a full 34-byte count.
- With `UART_TX_SCHED_FIXED_PRIO_EN` defined and requests 0 and 3 held → requester 0 is granted every time and requester 3 is starved.
